// File: rtl/tx_pkg.sv
// -----------------------------------------------------------------------------
// tx_pkg -- shared types and constants for the serial transmitter.
//
// Contents:
//   tx_state_t   : transmitter FSM state encoding
//   PAR_EVEN/ODD : parity type selector values
//   *_LEVEL      : serial line levels for idle, start and stop bits
//
// Optional feature macro: TX_PARITY_EN (adds the PARITY state).
// -----------------------------------------------------------------------------
package tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
`ifdef TX_PARITY_EN
    ,
    PARITY = 3'd4
`endif
  } tx_state_t;

  localparam logic PAR_EVEN    = 1'b0;
  localparam logic PAR_ODD     = 1'b1;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/tx_parity_calc.sv
// -----------------------------------------------------------------------------
// tx_parity_calc -- combinational parity bit generator.
//
// Ports:
//   data    [DATA_WIDTH-1:0] in  : word whose bits are covered by the parity
//   par_typ                  in  : PAR_EVEN (0) or PAR_ODD (1)
//   parity                   out : bit that makes the total count of ones
//                                  even (PAR_EVEN) or odd (PAR_ODD)
// -----------------------------------------------------------------------------
module tx_parity_calc
  import tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  parity
);

  // Reduction XOR is 1 when the word holds an odd number of ones; odd parity
  // inverts it.
  assign parity = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/tx_top.sv
// -----------------------------------------------------------------------------
// tx_top -- UART-style serial transmitter, one CLK period per bit.
//
// Frame on S_DATA: start (0), DATA_WIDTH data bits LSB first, optional
// parity bit, stop (1). The line idles high.
//
// Ports:
//   CLK        in  : clock, one period per bit time
//   RST        in  : synchronous active-high reset
//   PAR_EN     in  : 1 appends a parity bit (parity build only)
//   PAR_TYP    in  : 0 even parity, 1 odd parity (parity build only)
//   P_DATA     in  : parallel word to send
//   DATA_VALID in  : transmit request
//   S_DATA     out : registered serial line
//   BUSY       out : registered, high for every cycle of a frame
//   dbg_state  out : current FSM state, for observation only
//
// Handshake: a request is accepted on a CLK edge where the FSM is IDLE and
// DATA_VALID=1; P_DATA/PAR_EN/PAR_TYP are captured on that same edge. BUSY
// is the only back-pressure: DATA_VALID is ignored while BUSY=1 and nothing
// is queued. The start bit appears in the cycle right after the accepting
// edge, and BUSY drops for at least one cycle between frames.
//
// Optional feature macro: TX_PARITY_EN. Without it the PARITY state does not
// exist, PAR_EN/PAR_TYP are ignored and every frame is DATA_WIDTH+2 cycles.
// -----------------------------------------------------------------------------
module tx_top
  import tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  output logic                  S_DATA,
  output logic                  BUSY,
  output tx_state_t             dbg_state
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  tx_state_t               state, next_state;
  logic [CNT_W-1:0]        bit_cnt, cnt_next;
  logic [DATA_WIDTH-1:0]   data_reg;
  logic                    load;
  logic                    s_data_next;
  logic                    busy_next;
  logic                    parity_bit;

`ifdef TX_PARITY_EN
  logic par_en_q;
  logic par_typ_q;

  tx_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .data    (data_reg),
    .par_typ (par_typ_q),
    .parity  (parity_bit)
  );
`else
  // Parity is not part of this build: the calculator sees a constant type and
  // its result, along with the parity controls, goes nowhere.
  logic unused_cfg;

  tx_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .data    (data_reg),
    .par_typ (PAR_EVEN),
    .parity  (parity_bit)
  );

  assign unused_cfg = PAR_EN ^ PAR_TYP ^ parity_bit;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    cnt_next   = bit_cnt;
    load       = 1'b0;

    case (state)
      IDLE: begin
        if (DATA_VALID) begin
          next_state = START;
          load       = 1'b1;
        end
      end
      START: begin
        next_state = DATA;
        cnt_next   = '0;
      end
      DATA: begin
        if (bit_cnt == LAST_BIT) begin
`ifdef TX_PARITY_EN
          next_state = par_en_q ? PARITY : STOP;
`else
          next_state = STOP;
`endif
        end else begin
          cnt_next = bit_cnt + 1'b1;
        end
      end
`ifdef TX_PARITY_EN
      PARITY: begin
        next_state = STOP;
      end
`endif
      STOP: begin
        next_state = IDLE;
        cnt_next   = '0;
      end
      default: begin
        next_state = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode. The line and BUSY are registered, so they are decoded from
  // the state being entered; that puts the start bit on the line in the cycle
  // right after the accepting edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    s_data_next = IDLE_LEVEL;
    busy_next   = 1'b1;

    case (next_state)
      IDLE: begin
        s_data_next = IDLE_LEVEL;
        busy_next   = 1'b0;
      end
      START:  s_data_next = START_LEVEL;
      DATA:   s_data_next = data_reg[cnt_next];
`ifdef TX_PARITY_EN
      PARITY: s_data_next = parity_bit;
`endif
      STOP:   s_data_next = STOP_LEVEL;
      default: begin
        s_data_next = IDLE_LEVEL;
        busy_next   = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, counter, capture and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      data_reg <= '0;
      S_DATA   <= IDLE_LEVEL;
      BUSY     <= 1'b0;
`ifdef TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_typ_q <= PAR_EVEN;
`endif
    end else begin
      state   <= next_state;
      bit_cnt <= cnt_next;
      S_DATA  <= s_data_next;
      BUSY    <= busy_next;
      // Capture everything the frame needs so later input changes cannot
      // disturb the frame in flight.
      if (load) begin
        data_reg <= P_DATA;
`ifdef TX_PARITY_EN
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
`endif
      end
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_tx_top.sv
// -----------------------------------------------------------------------------
// tb_tx_top -- self-checking bench for tx_top.
//
// A frame-level model turns every accepted request into the list of
// (BUSY, S_DATA) pairs the line must show, one per cycle; a compare process
// checks the DUT against it on every falling edge. Directed scenarios pin the
// model with hand-written bit strings, then randomized traffic runs.
// Honours TX_PARITY_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_tx_top;
  import tx_pkg::*;

  localparam int DW = 8;

`ifdef TX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic [DW-1:0] P_DATA;
  logic          DATA_VALID;
  logic          S_DATA;
  logic          BUSY;
  tx_state_t     dbg_state;

  int tests = 0;
  int fails = 0;

  // Expected {BUSY, S_DATA} per cycle for the frame in flight.
  logic [1:0] exp_q[$];
  bit         model_ok = 1'b0;

  tx_top #(.DATA_WIDTH(DW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .S_DATA     (S_DATA),
    .BUSY       (BUSY),
    .dbg_state  (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic void push_frame(input logic [DW-1:0] d, input logic pe, input logic pt);
    bit with_par;
    with_par = PAR_ON & pe;
    exp_q.push_back(2'b10);                         // start bit
    for (int i = 0; i < DW; i++) exp_q.push_back({1'b1, d[i]});
    if (with_par) exp_q.push_back({1'b1, (^d) ^ pt});
    exp_q.push_back(2'b11);                         // stop bit
  endfunction

  always @(posedge CLK) begin
    if (RST === 1'b1) begin
      exp_q.delete();
      model_ok = 1'b1;
    end else if (model_ok) begin
      if (exp_q.size() != 0) exp_q.delete(0);
      else if (DATA_VALID === 1'b1) push_frame(P_DATA, PAR_EN, PAR_TYP);
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard compare, every cycle once reset has been seen
  // ---------------------------------------------------------------------------
  always @(negedge CLK) begin
    logic [1:0] e;
    if (model_ok) begin
      e = (exp_q.size() != 0) ? exp_q[0] : 2'b01;
      tests++;
      if (({BUSY, S_DATA} !== e) || ((dbg_state == IDLE) !== !e[1])) begin
        fails++;
        $display("FAIL line t=%0t got busy,s_data=%b%b state=%0d expected busy,s_data=%b%b",
                 $time, BUSY, S_DATA, dbg_state, e[1], e[0]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver / check tasks
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic chk_str(input string name, input string got, input string exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%s expected=%s", name, got, exp);
    end
  endtask

  // Issue a one-cycle request from idle and record the line for as long as
  // BUSY stays high. inject >= 0 pulses a competing 8'h0F request at that
  // frame cycle.
  task automatic send_capture(input string name, input logic [DW-1:0] d, input logic pe,
                              input logic pt, input int inject, input string exp_s);
    string got;
    int    n;
    got = "";
    n   = 0;
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; DATA_VALID = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;
    while (BUSY === 1'b1 && n < 20) begin
      got = {got, (S_DATA === 1'b1) ? "1" : "0"};
      if (n == inject) begin
        P_DATA = 8'h0F; PAR_EN = ~pe; PAR_TYP = ~pt; DATA_VALID = 1'b1;
      end else begin
        DATA_VALID = 1'b0;
      end
      n++;
      @(negedge CLK);
    end
    DATA_VALID = 1'b0;
    chk_str({name, "_bits"}, got, exp_s);
    chk({name, "_busy_len"}, n, exp_s.len());
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    string busy_s;
    string busy_exp;
    int    guard;

    RST = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0; P_DATA = '0; DATA_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_s_data", S_DATA, 1);
    chk("reset_busy", BUSY, 0);
    chk("reset_state", dbg_state, IDLE);
    RST = 1'b0;
    @(negedge CLK);

    // 8'hFE even parity: ones=7 -> parity 1
    send_capture("fe_even", 8'hFE, 1'b1, 1'b0, -1,
                 PAR_ON ? "00111111111" : "0011111111");
    // 8'hAA odd parity: ones=4 -> parity 1
    send_capture("aa_odd", 8'hAA, 1'b1, 1'b1, -1,
                 PAR_ON ? "00101010111" : "0010101011");
    // 8'hAA without parity
    send_capture("aa_nopar", 8'hAA, 1'b0, 1'b0, -1, "0010101011");
    // 8'h0F odd parity: ones=4 -> parity 1
    send_capture("0f_odd", 8'h0F, 1'b1, 1'b1, -1,
                 PAR_ON ? "01111000011" : "0111100001");

    // Reset while data bit 3 of an 8'h55 frame is on the line
    P_DATA = 8'h55; PAR_EN = 1'b1; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
    @(negedge CLK);                  // start bit
    DATA_VALID = 1'b0;
    repeat (4) @(negedge CLK);       // data bits 0..3
    chk("abort_bit3_on_line", S_DATA, 0);
    RST = 1'b1;
    @(negedge CLK);
    chk("abort_s_data", S_DATA, 1);
    chk("abort_busy", BUSY, 0);
    RST = 1'b0;
    send_capture("after_abort", 8'h55, 1'b0, 1'b0, -1, "0101010101");

    // Competing request during a busy frame must be dropped
    send_capture("ignore_busy", 8'hAA, 1'b0, 1'b0, 4, "0010101011");
    repeat (3) @(negedge CLK);
    chk("ignore_stays_idle", BUSY, 0);

    // DATA_VALID held high: 10 busy cycles, 1 idle, repeating
    PAR_EN = 1'b0; PAR_TYP = 1'b0; P_DATA = 8'h3C; DATA_VALID = 1'b1;
    busy_s = "";
    busy_exp = "";
    for (int f = 0; f < 3; f++) busy_exp = {busy_exp, "11111111110"};
    for (int c = 0; c < 33; c++) begin
      @(negedge CLK);
      busy_s = {busy_s, (BUSY === 1'b1) ? "1" : "0"};
    end
    chk_str("back_to_back_busy", busy_s, busy_exp);
    DATA_VALID = 1'b0;
    guard = 0;
    while (BUSY !== 1'b0 && guard < 30) begin
      @(negedge CLK);
      guard++;
    end
    chk("back_to_back_drain", BUSY, 0);

    // Randomized traffic with mid-frame input changes and occasional resets
    repeat (3000) begin
      @(negedge CLK);
      RST        = ($urandom_range(0, 199) == 0);
      DATA_VALID = ($urandom_range(0, 9) < 4);
      P_DATA     = DW'($urandom_range(0, 255));
      PAR_EN     = $urandom_range(0, 1) == 1;
      PAR_TYP    = $urandom_range(0, 1) == 1;
    end
    @(negedge CLK);
    RST = 1'b0;
    DATA_VALID = 1'b0;
    repeat (15) @(negedge CLK);
    chk("final_idle_busy", BUSY, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tx_top.md
TX_TOP -- requirements
Module: tx_top

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 8, the number of payload bits per frame.
REQ-002 SHALL provide port CLK, input, 1 bit, the single clock; one CLK period equals one bit time.
REQ-003 SHALL provide port RST, input, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL provide port PAR_EN, input, 1 bit: 1 inserts a parity bit after the data bits.
REQ-005 SHALL provide port PAR_TYP, input, 1 bit: 0 selects even parity, 1 selects odd parity.
REQ-006 SHALL provide port P_DATA, input, DATA_WIDTH bits: the parallel word to transmit.
REQ-007 SHALL provide port DATA_VALID, input, 1 bit: a transmit request, qualified only while idle.
REQ-008 SHALL provide port S_DATA, output, 1 bit: the serial line, registered, idle-high.
REQ-009 SHALL provide port BUSY, output, 1 bit, registered: high while a frame is on the line.

Function
REQ-010 SHALL implement FSM states IDLE, START, DATA, PARITY and STOP, each bit lasting exactly one CLK cycle.
REQ-011 In IDLE, S_DATA=1 and BUSY=0.
REQ-012 On an edge in IDLE with DATA_VALID=1, SHALL latch P_DATA, PAR_EN and PAR_TYP, then go to START.
REQ-013 The start bit, S_DATA=0 and BUSY=1, SHALL appear in the cycle immediately after the accepting edge; latency is 1 cycle.
REQ-014 DATA SHALL shift out the latched word LSB first over DATA_WIDTH cycles, using a counter from 0 to DATA_WIDTH-1.
REQ-015 PARITY state, entered only if latched PAR_EN=1, SHALL drive the XOR of the data bits for even parity and the inverse of that XOR for odd parity.
REQ-016 STOP SHALL drive S_DATA=1 for one cycle with BUSY=1, then go to IDLE; frames are 11 cycles long with parity and 10 without.
REQ-017 DATA_VALID SHALL be ignored while BUSY=1; there is no queueing, and a new frame requires an IDLE cycle before its start bit.
REQ-018 Changes to P_DATA, PAR_EN or PAR_TYP mid-frame SHALL NOT affect the frame in flight.
REQ-019 DATA_VALID held high continuously SHALL start back-to-back frames, each separated by exactly one idle cycle.

Reset
REQ-020 With RST=1 at a CLK edge, the state SHALL become IDLE, S_DATA 1, BUSY 0, the bit counter 0 and the data register 0.
REQ-021 Reset SHALL take priority over DATA_VALID; reset mid-frame aborts the frame and the line returns high on the next cycle.

Configuration
REQ-022 With macro TX_PARITY_EN defined, parity SHALL behave as REQ-015.
REQ-023 Without TX_PARITY_EN, SHALL omit the PARITY state and parity logic, ignore PAR_EN and PAR_TYP, and produce 10-cycle frames always.

Structure
REQ-024 Package tx_pkg SHALL hold the FSM state enum typedef and the constants PAR_EVEN=0, PAR_ODD=1, IDLE_LEVEL=1, START_LEVEL=0 and STOP_LEVEL=1.
REQ-025 A single sub-module, tx_parity_calc, SHALL compute parity combinationally from the data and type inputs; the FSM, serializer and output registers SHALL reside in tx_top.

Verification
REQ-026 Scenario: RST pulse, then PAR_EN=1, PAR_TYP=0, P_DATA=8'hFE and a 1-cycle DATA_VALID -> S_DATA shows 0, then 0,1,1,1,1,1,1,1, then parity 1, then stop 1; BUSY is high for exactly 11 cycles.
REQ-027 Scenario: PAR_EN=1, PAR_TYP=1, P_DATA=8'hAA -> S_DATA shows 0, then 0,1,0,1,0,1,0,1, then parity 1, then stop 1; BUSY is high for 11 cycles.
REQ-028 Scenario: PAR_EN=0, P_DATA=8'hAA -> S_DATA shows 0, then 0,1,0,1,0,1,0,1, then stop 1; BUSY is high for 10 cycles.
REQ-029 Scenario: RST=1 asserted during data bit 3 of an 8'h55 frame -> next cycle S_DATA=1 and BUSY=0, and a subsequent request transmits a clean frame.
REQ-030 Scenario: DATA_VALID pulsed with 8'h0F during a busy frame -> the request is ignored and only the original frame is transmitted.
REQ-031 Scenario: DATA_VALID held high with PAR_EN=0 -> consecutive 10-cycle frames, each separated by one idle-high cycle.
